load_writeback_unit: RTL and testbench

LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

---
 rtl/lwb_pkg.sv | 36 +++
 rtl/lwb_align.sv | 47 ++++
 rtl/load_writeback_unit.sv | 159 +++++++++++++++
 tb/tb_load_writeback_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lwb_pkg.sv
// lwb_pkg: load opcodes, pending-load entry type and byte-enable helpers for load_writeback_unit
package lwb_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'b0000,
      OP_LBU = 4'b0001,
      OP_LW  = 4'b0010,
      OP_LWL = 4'b0011,
      OP_LH  = 4'b0100,
      OP_LWR = 4'b0101,
      OP_LHU = 4'b0110
   } lwb_memop_e;

   // memop is kept as raw bits: codes outside the enum are legal and behave as LW
   typedef struct packed {
      logic [3:0]  memop;
      logic [1:0]  addr_lo;
      logic [4:0]  rd;
      logic [31:0] rt_old;
      logic [31:0] data;
      logic        done;
   } lwb_entry_t;

   // LWL fills from the top byte down to the offset, LWR from the bottom byte up to it
   function automatic logic [3:0] lwb_be(input logic [3:0] op, input logic [1:0] off);
      return op == OP_LWL ? 4'b1111 << off : op == OP_LWR ? 4'b1111 >> ~off : 4'b1111;
   endfunction

   function automatic logic lwb_misaligned(input logic [3:0] op, input logic [1:0] off);
      logic is_half, is_word;
      is_half = op == OP_LH || op == OP_LHU;
      is_word = !(is_half || op == OP_LB || op == OP_LBU || op == OP_LWL || op == OP_LWR);
      return (is_word && off != 2'b00) || (is_half && off[0]);
   endfunction

endpackage

// File: rtl/lwb_align.sv
// lwb_align: byte/half select with extension and lwl/lwr merge for one returned load word
//   memop, off    : opcode and byte offset of the load
//   rt_old        : old destination value, supplies bytes outside the enables
//   mem_data      : aligned memory word
//   data, be, exc : write-back data, byte enables, misalign flag
//   Macro LWB_MISALIGN_EXC_EN enables misalign exceptions (be forced to 0000).
module lwb_align
   import lwb_pkg::*;
(
   input  logic [3:0]  memop,
   input  logic [1:0]  off,
   input  logic [31:0] rt_old,
   input  logic [31:0] mem_data,
   output logic [31:0] data,
   output logic [3:0]  be,
   output logic        exc
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] shift_v;
   logic [31:0] merge_v;
   logic [3:0]  be_v;

   always_comb begin
      byte_v  = mem_data[{off, 3'b000} +: 8];
      half_v  = off[1] ? mem_data[31:16] : mem_data[15:0];
      // LWR shifts right by 3-off bytes; ~off equals 3-off for a 2-bit offset
      shift_v = memop == OP_LWL ? mem_data << {off, 3'b000} : mem_data >> {~off, 3'b000};
      be_v    = lwb_be(memop, off);
      merge_v = rt_old;
      for (int i = 0; i < 4; i++)
         merge_v[8*i +: 8] = be_v[i] ? shift_v[8*i +: 8] : rt_old[8*i +: 8];
      data = memop == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
             memop == OP_LBU ? {24'h0, byte_v} :
             memop == OP_LH  ? {{16{half_v[15]}}, half_v} :
             memop == OP_LHU ? {16'h0, half_v} :
             (memop == OP_LWL || memop == OP_LWR) ? merge_v : mem_data;
`ifdef LWB_MISALIGN_EXC_EN
      exc = lwb_misaligned(memop, off);
`else
      exc = 1'b0;
`endif
      be = exc ? 4'b0000 : be_v;
   end

endmodule

// File: rtl/load_writeback_unit.sv
// load_writeback_unit: in-order pending-load queue that aligns returned words and hands them to write-back
//   req_*     : load issue (valid/ready, memop, addr_lo, rd, rt_old)
//   rsp_*     : in-order memory words, no backpressure
//   flush     : drop all pending loads; responses still in flight are discarded via kill credits
//   wb_*      : registered write-back (valid/ready, rd, data, be, exc)
//   pending   : occupied queue entries
//   Macro LWB_MISALIGN_EXC_EN enables misaligned LW/LH/LHU exceptions.
module load_writeback_unit
   import lwb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             req_memop,
   input  logic [1:0]             req_addr_lo,
   input  logic [4:0]             req_rd,
   input  logic [DATA_W-1:0]      req_rt_old,
   input  logic                   rsp_valid,
   input  logic [DATA_W-1:0]      rsp_data,
   input  logic                   flush,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [4:0]             wb_rd,
   output logic [DATA_W-1:0]      wb_data,
   output logic [3:0]             wb_be,
   output logic                   wb_exc,
   output logic [$clog2(DEPTH):0] pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("load_writeback_unit: DATA_W must be 32");
   end
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("load_writeback_unit: DEPTH must be a power of 2 in 2..16");
   end

   lwb_entry_t      ent_q [DEPTH];
   lwb_entry_t      ent_d [DEPTH];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d, rptr;
   logic [CW-1:0]   count_q, count_d, done_cnt_q, done_cnt_d, kill_q, kill_d;
   logic            live_q, live_d;
   logic            wb_valid_q, wb_valid_d, wb_exc_q, wb_exc_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [31:0]     wb_data_q, wb_data_d;
   logic [3:0]      wb_be_q, wb_be_d;
   logic            accept, rsp_hit, rsp_kill, head_done, pop;
   lwb_entry_t      head_ent;
   logic [31:0]     head_data, al_data;
   logic [3:0]      al_be;
   logic            al_exc;

   always_comb begin
      // done entries are contiguous from the head, so the next response target is head + done count
      rptr      = head_q + done_cnt_q[PW-1:0];
      req_ready = live_q && count_q < DEPTH_C && kill_q == '0;
      accept    = req_valid && req_ready && !flush;
      rsp_kill  = rsp_valid && kill_q != '0;
      rsp_hit   = rsp_valid && kill_q == '0 && done_cnt_q != count_q;
      head_ent  = ent_q[head_q];
      // a response landing on the head bypasses the queue so the output loads in the same edge
      head_done = count_q != '0 && (head_ent.done || (rsp_hit && done_cnt_q == '0));
      head_data = head_ent.done ? head_ent.data : rsp_data;
      pop       = head_done && (!wb_valid_q || wb_ready) && !flush;
   end

   lwb_align u_align (
      .memop    (head_ent.memop),
      .off      (head_ent.addr_lo),
      .rt_old   (head_ent.rt_old),
      .mem_data (head_data),
      .data     (al_data),
      .be       (al_be),
      .exc      (al_exc)
   );

   always_comb begin
      ent_d = ent_q;
      if (rsp_hit) begin
         ent_d[rptr].data = rsp_data;
         ent_d[rptr].done = 1'b1;
      end
      if (pop)
         ent_d[head_q].done = 1'b0;
      if (accept) begin
         ent_d[tail_q].memop   = req_memop;
         ent_d[tail_q].addr_lo = req_addr_lo;
         ent_d[tail_q].rd      = req_rd;
         ent_d[tail_q].rt_old  = req_rt_old;
         ent_d[tail_q].data    = '0;
         ent_d[tail_q].done    = 1'b0;
      end
      if (flush)
         for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      head_d     = flush ? '0 : head_q + PW'(pop);
      tail_d     = flush ? '0 : tail_q + PW'(accept);
      count_d    = flush ? '0 : count_q + CW'(accept) - CW'(pop);
      done_cnt_d = flush ? '0 : done_cnt_q + CW'(rsp_hit) - CW'(pop);
      // every entry still waiting on memory when flushed owes one response to discard
      kill_d     = kill_q - CW'(rsp_kill) + (flush ? count_q - done_cnt_q - CW'(rsp_hit) : '0);
      live_d     = 1'b1;
      wb_valid_d = flush ? 1'b0 : pop ? 1'b1 : wb_ready ? 1'b0 : wb_valid_q;
      wb_rd_d    = pop ? head_ent.rd : wb_rd_q;
      wb_data_d  = pop ? al_data : wb_data_q;
      wb_be_d    = pop ? al_be : wb_be_q;
      wb_exc_d   = pop ? al_exc : wb_exc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         done_cnt_q <= '0;
         kill_q     <= '0;
         live_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_be_q    <= '0;
         wb_exc_q   <= 1'b0;
      end else begin
         ent_q      <= ent_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         done_cnt_q <= done_cnt_d;
         kill_q     <= kill_d;
         live_q     <= live_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_be_q    <= wb_be_d;
         wb_exc_q   <= wb_exc_d;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign wb_be    = wb_be_q;
   assign wb_exc   = wb_exc_q;
   assign pending  = count_q;

`ifndef SYNTHESIS
   a_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_valid |-> (kill_q != '0 || done_cnt_q != count_q))
      else $error("load_writeback_unit: rsp_valid with no outstanding load");
`endif

endmodule

// File: tb/tb_load_writeback_unit.sv
// tb_load_writeback_unit: directed vectors with hand-computed results for load_writeback_unit
module tb_load_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [3:0]  req_memop;
   logic [1:0]  req_addr_lo;
   logic [4:0]  req_rd;
   logic [31:0] req_rt_old;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        flush;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [3:0]  wb_be;
   logic        wb_exc;
   logic [2:0]  pending;
   int          vecs = 0;
   int          errs = 0;

   load_writeback_unit dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_memop(req_memop), .req_addr_lo(req_addr_lo), .req_rd(req_rd), .req_rt_old(req_rt_old),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_be(wb_be), .wb_exc(wb_exc),
      .pending(pending)
   );

   always #5 clk = ~clk;

   // alignment table: opcode, offset, rt_old, memory word, expected data, expected enables
   logic [3:0]  t_op   [9] = '{4'b0000, 4'b0001, 4'b0100, 4'b0110, 4'b0101, 4'b0011, 4'b0101, 4'b0000, 4'b1111};
   logic [1:0]  t_off  [9] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0};
   logic [31:0] t_rt   [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'h0, 32'h0};
   logic [31:0] t_rsp  [9] = '{32'h0080FF00, 32'h0080FF00, 32'h80017FFF, 32'h80017FFF, 32'h11223344,
                               32'h11223344, 32'h11223344, 32'h7F000000, 32'hCAFEF00D};
   logic [31:0] t_exp  [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00007FFF, 32'hAABB1122,
                               32'h44BBCCDD, 32'h11223344, 32'h0000007F, 32'hCAFEF00D};
   logic [3:0]  t_be   [9] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h3, 4'h8, 4'hF, 4'hF, 4'hF};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] off, input logic [4:0] rd, input logic [31:0] rt);
      req_memop = op; req_addr_lo = off; req_rd = rd; req_rt_old = rt; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      rsp_data = d; rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
      req_memop = '0; req_addr_lo = '0; req_rd = '0; req_rt_old = '0; rsp_data = '0;
      repeat (3) tick();
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
      vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL rst_pending got=%0d exp=0", pending); end
      vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
      vecs++; if ({wb_rd, wb_data, wb_be, wb_exc} !== 42'h0) begin errs++; $display("FAIL rst_wb_fields got=%h exp=0", {wb_rd, wb_data, wb_be, wb_exc}); end
      rst_n = 1'b1;
      vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_release_ready got=%b exp=0", req_ready); end
      tick();
      vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_rise got=%b exp=1", req_ready); end
   endtask

   task automatic test_lwl();
      issue(4'b0011, 2'd1, 5'd5, 32'hAABBCCDD);
      vecs++; if (pending !== 3'd1) begin errs++; $display("FAIL lwl_pending got=%0d exp=1", pending); end
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL lwl_early_valid got=%b exp=0", wb_valid); end
      respond(32'h11223344);
      vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL lwl_latency got=%b exp=1", wb_valid); end
      vecs++; if (wb_data !== 32'h223344DD) begin errs++; $display("FAIL lwl_data got=%h exp=223344dd", wb_data); end
      vecs++; if (wb_be !== 4'b1110) begin errs++; $display("FAIL lwl_be got=%b exp=1110", wb_be); end
      vecs++; if (wb_rd !== 5'd5) begin errs++; $display("FAIL lwl_rd got=%0d exp=5", wb_rd); end
      vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL lwl_pop got=%0d exp=0", pending); end
      tick();
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL lwl_drain got=%b exp=0", wb_valid); end
   endtask

   task automatic test_align();
      for (int i = 0; i < 9; i++) begin
         issue(t_op[i], t_off[i], 5'(i + 1), t_rt[i]);
         respond(t_rsp[i]);
         vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL align%0d_valid got=%b exp=1", i, wb_valid); end
         vecs++; if (wb_data !== t_exp[i]) begin errs++; $display("FAIL align%0d_data got=%h exp=%h", i, wb_data, t_exp[i]); end
         vecs++; if (wb_be !== t_be[i]) begin errs++; $display("FAIL align%0d_be got=%b exp=%b", i, wb_be, t_be[i]); end
         vecs++; if (wb_exc !== 1'b0) begin errs++; $display("FAIL align%0d_exc got=%b exp=0", i, wb_exc); end
         tick();
      end
   endtask

   task automatic test_misalign();
      issue(4'b0010, 2'd2, 5'd9, 32'h0);
      respond(32'hDEADBEEF);
      vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL mis_valid got=%b exp=1", wb_valid); end
`ifdef LWB_MISALIGN_EXC_EN
      vecs++; if (wb_exc !== 1'b1) begin errs++; $display("FAIL mis_exc got=%b exp=1", wb_exc); end
      vecs++; if (wb_be !== 4'b0000) begin errs++; $display("FAIL mis_be got=%b exp=0000", wb_be); end
`else
      vecs++; if (wb_exc !== 1'b0) begin errs++; $display("FAIL mis_exc got=%b exp=0", wb_exc); end
      vecs++; if (wb_data !== 32'hDEADBEEF) begin errs++; $display("FAIL mis_data got=%h exp=deadbeef", wb_data); end
      vecs++; if (wb_be !== 4'b1111) begin errs++; $display("FAIL mis_be got=%b exp=1111", wb_be); end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      issue(4'b0010, 2'd0, 5'd3, 32'h0);
      req_memop = 4'b0010; req_addr_lo = 2'd0; req_rd = 5'd4; req_valid = 1'b1;
      rsp_data = 32'hA5A5A5A5; rsp_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      vecs++; if (pending !== 3'd1) begin errs++; $display("FAIL b2b_pending got=%0d exp=1", pending); end
      vecs++; if (wb_rd !== 5'd3 || wb_data !== 32'hA5A5A5A5) begin errs++; $display("FAIL b2b_first got=%0d/%h exp=3/a5a5a5a5", wb_rd, wb_data); end
      rsp_data = 32'h5A5A5A5A;
      tick();
      rsp_valid = 1'b0;
      vecs++; if (wb_rd !== 5'd4 || wb_data !== 32'h5A5A5A5A) begin errs++; $display("FAIL b2b_second got=%0d/%h exp=4/5a5a5a5a", wb_rd, wb_data); end
      vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL b2b_empty got=%0d exp=0", pending); end
      tick();
   endtask

   task automatic test_full();
      req_memop = 4'b0010; req_addr_lo = 2'd0; req_rt_old = 32'h0; req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_rd = 5'(10 + i);
         tick();
      end
      req_valid = 1'b0;
      vecs++; if (pending !== 3'd4) begin errs++; $display("FAIL full_pending got=%0d exp=4", pending); end
      vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL full_ready got=%b exp=0", req_ready); end
      respond(32'h100);
      vecs++; if (pending !== 3'd3) begin errs++; $display("FAIL full_pop got=%0d exp=3", pending); end
      vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL full_ready_back got=%b exp=1", req_ready); end
      vecs++; if (wb_rd !== 5'd10) begin errs++; $display("FAIL full_rd0 got=%0d exp=10", wb_rd); end
      for (int i = 1; i < 4; i++) begin
         respond(32'h100 + 32'(i));
         vecs++; if (wb_rd !== 5'(10 + i) || wb_data !== 32'h100 + 32'(i)) begin errs++; $display("FAIL full_rd%0d got=%0d/%h exp=%0d/%h", i, wb_rd, wb_data, 10 + i, 32'h100 + 32'(i)); end
      end
      tick();
      vecs++; if (pending !== 3'd0 || wb_valid !== 1'b0) begin errs++; $display("FAIL full_drain got=%0d/%b exp=0/0", pending, wb_valid); end
   endtask

   task automatic test_hold();
      wb_ready = 1'b0;
      issue(4'b0010, 2'd0, 5'd1, 32'h0);
      issue(4'b0010, 2'd0, 5'd2, 32'h0);
      respond(32'h111);
      vecs++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1) begin errs++; $display("FAIL hold_first got=%b/%0d exp=1/1", wb_valid, wb_rd); end
      respond(32'h222);
      for (int i = 0; i < 4; i++) begin
         vecs++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h111 || wb_be !== 4'hF || pending !== 3'd1) begin
            errs++; $display("FAIL hold_stable%0d got=%b/%0d/%h/%b/%0d exp=1/1/00000111/1111/1", i, wb_valid, wb_rd, wb_data, wb_be, pending);
         end
         tick();
      end
      wb_ready = 1'b1;
      tick();
      vecs++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h222) begin errs++; $display("FAIL hold_release got=%b/%0d/%h exp=1/2/00000222", wb_valid, wb_rd, wb_data); end
      tick();
      vecs++; if (wb_valid !== 1'b0 || pending !== 3'd0) begin errs++; $display("FAIL hold_drain got=%b/%0d exp=0/0", wb_valid, pending); end
   endtask

   task automatic test_flush();
      issue(4'b0010, 2'd0, 5'd20, 32'h0);
      issue(4'b0010, 2'd0, 5'd21, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL flush_pending got=%0d exp=0", pending); end
      vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
      respond(32'h12345678);
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL flush_kill0 got=%b exp=0", wb_valid); end
      respond(32'h87654321);
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL flush_kill1 got=%b exp=0", wb_valid); end
      vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL flush_ready_back got=%b exp=1", req_ready); end
      issue(4'b0000, 2'd0, 5'd7, 32'h0);
      respond(32'h000000AB);
      vecs++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hFFFFFFAB) begin errs++; $display("FAIL flush_after got=%b/%0d/%h exp=1/7/ffffffab", wb_valid, wb_rd, wb_data); end
      tick();
      req_valid = 1'b1; flush = 1'b1;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL flush_wins got=%0d exp=0", pending); end
      vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL flush_empty_ready got=%b exp=1", req_ready); end
   endtask

   initial begin
      test_reset();
      test_lwl();
      test_align();
      test_misalign();
      test_back_to_back();
      test_full();
      test_hold();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
